// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//
// Bundles the signals between the boot loader, its byte source, the
// instruction memory write port and the core-control/status outputs.
//
//   rx_valid    byte source -> loader : byte available on rx_data
//   rx_data     byte source -> loader : stream byte
//   rx_ready    loader -> byte source : loader can take a byte this cycle
//   imem_we     loader -> imem        : one-cycle write strobe
//   imem_addr   loader -> imem        : word index being written
//   imem_wdata  loader -> imem        : assembled 32-bit instruction word
//   core_rst    loader -> core        : held high until a verified load
//   done        loader -> status      : sticky, load good
//   error       loader -> status      : sticky, load failed
//   err_code    loader -> status      : 0 none, 1 size, 2 checksum, 3 timeout
//
// Modports:
//   master : the environment (byte source, memory, status observer)
//   slave  : the boot loader itself
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
   parameter int ADDR_W = 10
);
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              error;
   logic [1:0]        err_code;

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  imem_we,
      input  imem_addr,
      input  imem_wdata,
      input  core_rst,
      input  done,
      input  error,
      input  err_code
   );

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output imem_we,
      output imem_addr,
      output imem_wdata,
      output core_rst,
      output done,
      output error,
      output err_code
   );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Receives a program image as a byte stream, assembles it into 32-bit words
// and writes them into instruction memory. The pipeline core is held in
// reset until the whole image has arrived and its checksum matches.
//
// Frame: N_lo, N_hi (16-bit word count, little-endian), N*4 payload bytes
// (each word little-endian), one checksum byte (mod-256 sum of payload).
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   imem_boot_loader_if.slave : rx byte stream handshake, imem write
//         port, core_rst, done/error/err_code status
//
// Parameters:
//   IMEM_DEPTH      memory depth in words; largest accepted word count
//   ADDR_W          imem_addr width, 2**ADDR_W >= IMEM_DEPTH
//   TIMEOUT_CYCLES  idle cycles tolerated between bytes once a load started
// ---------------------------------------------------------------------------
module imem_boot_loader #(
   parameter int IMEM_DEPTH     = 1024,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   imem_boot_loader_if.slave     bus
);

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_SIZE    = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [16:0] DEPTH_LIMIT = 17'(IMEM_DEPTH);

   // The counter may step one past the last idle cycle on the way into ERR,
   // so size it to hold TIMEOUT_CYCLES itself.
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   // Payload checksum: plain 8-bit sum, wrapping mod 256.
   function automatic logic [7:0] csum_add(input logic [7:0] acc,
                                           input logic [7:0] b);
      logic [7:0] sum;
      sum = acc + b;
      return sum;
   endfunction

   state_t            state;
   logic [7:0]        n_lo;
   logic [15:0]       n_words;
   logic [15:0]       word_cnt;
   logic [1:0]        byte_cnt;
   logic [23:0]       asm_word;
   logic [7:0]        csum;
   logic [TMO_W-1:0]  tmo_cnt;

   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [31:0]       wdata_p1;

   logic              core_rst_r;
   logic              done_r;
   logic              error_r;
   logic [1:0]        err_code_r;

   logic              rx_ready_int;
   logic              timed_state;
   logic              tmo_hit;
   logic [15:0]       n_next;

   // ---- stage p0: byte acceptance --------------------------------------
   // rx_ready depends only on state; it is forced low while rst is held so
   // that the reset-time value is 0 even though HDR_LO itself is ready.
   assign rx_ready_int = !rst && (state == HDR_LO || state == HDR_HI ||
                                  state == DATA   || state == CHK);

   logic       vld_p0;
   logic [7:0] data_p0;
   assign vld_p0  = bus.rx_valid && rx_ready_int;
   assign data_p0 = bus.rx_data;

   assign timed_state = (state == HDR_HI) || (state == DATA) || (state == CHK);
   assign tmo_hit     = (tmo_cnt == TMO_LAST);
   assign n_next      = {data_p0, n_lo};

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HDR_LO;
         n_lo       <= '0;
         n_words    <= '0;
         word_cnt   <= '0;
         byte_cnt   <= '0;
         asm_word   <= '0;
         csum       <= '0;
         tmo_cnt    <= '0;
         vld_p1     <= 1'b0;
         addr_p1    <= '0;
         wdata_p1   <= '0;
         core_rst_r <= 1'b1;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         err_code_r <= ERR_NONE;
      end else begin
         vld_p1 <= 1'b0;

         // Idle counter: runs only while a load is in flight; any accepted
         // byte (and therefore every state entry, since transitions happen
         // on accepted bytes) restarts it.
         if (timed_state && !vld_p0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end

         case (state)
            HDR_LO: begin
               if (vld_p0) begin
                  n_lo  <= data_p0;
                  state <= HDR_HI;
               end
            end

            HDR_HI: begin
               if (vld_p0) begin
                  n_words  <= n_next;
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  csum     <= '0;
                  if ({1'b0, n_next} > DEPTH_LIMIT) begin
                     state      <= ERR;
                     error_r    <= 1'b1;
                     err_code_r <= ERR_SIZE;
                  end else if (n_next == 16'd0) begin
                     state <= CHK;
                  end else begin
                     state <= DATA;
                  end
               end
            end

            DATA: begin
               if (vld_p0) begin
                  csum     <= csum_add(csum, data_p0);
                  byte_cnt <= byte_cnt + 2'd1;
                  // Little-endian assembly: each new byte enters at the top
                  // and earlier bytes slide toward bit 0.
                  asm_word <= {data_p0, asm_word[23:8]};
                  if (byte_cnt == 2'd3) begin
                     // ---- stage p1: registered memory write ----------------
                     vld_p1   <= 1'b1;
                     addr_p1  <= word_cnt[ADDR_W-1:0];
                     wdata_p1 <= {data_p0, asm_word};
                     word_cnt <= word_cnt + 16'd1;
                     if (word_cnt == n_words - 16'd1) begin
                        state <= CHK;
                     end
                  end
               end
            end

            CHK: begin
               if (vld_p0) begin
                  if (data_p0 == csum) begin
                     state      <= DONE;
                     done_r     <= 1'b1;
                     core_rst_r <= 1'b0;
                  end else begin
                     state      <= ERR;
                     error_r    <= 1'b1;
                     err_code_r <= ERR_CSUM;
                  end
               end
            end

            DONE: begin
               state <= DONE;
            end

            ERR: begin
               state <= ERR;
            end

            default: begin
               state <= HDR_LO;
            end
         endcase

         // A byte arriving on the very cycle the limit is reached wins:
         // timeout is only taken when nothing was accepted.
         if (timed_state && !vld_p0 && tmo_hit) begin
            state      <= ERR;
            error_r    <= 1'b1;
            err_code_r <= ERR_TIMEOUT;
         end
      end
   end

   assign bus.rx_ready   = rx_ready_int;
   assign bus.imem_we    = vld_p1;
   assign bus.imem_addr  = addr_p1;
   assign bus.imem_wdata = wdata_p1;
   assign bus.core_rst   = core_rst_r;
   assign bus.done       = done_r;
   assign bus.error      = error_r;
   assign bus.err_code   = err_code_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed bench for imem_boot_loader with a short timeout (16 cycles).
// A negedge monitor logs every imem write; each test task drives a frame
// and compares status outputs and the write log against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

   localparam int ADDR_W = 10;
   localparam int TMO    = 16;

   localparam logic [31:0] WORD0 = 32'h0050_0093;
   localparam logic [31:0] WORD1 = 32'h00A0_0113;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   imem_boot_loader_if #(.ADDR_W(ADDR_W)) bus();

   imem_boot_loader #(
      .IMEM_DEPTH     (1024),
      .ADDR_W         (ADDR_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [7:0] good_frame [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                   8'h13, 8'h01, 8'hA0, 8'h00, 8'h97};

   logic [ADDR_W-1:0] wr_addr_q [$];
   logic [31:0]       wr_data_q [$];

   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         wr_addr_q.push_back(bus.imem_addr);
         wr_data_q.push_back(bus.imem_wdata);
      end
   end

   // Present one byte after 'gap' idle cycles; returns 1 time unit after
   // the edge that takes it.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bus.rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_good(input int count, input int gap);
      for (int i = 0; i < count; i++) begin
         send_byte(good_frame[i], gap);
      end
   endtask

   task automatic do_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic test_reset();
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b1_0_0_00) begin
         $display("FAIL reset_status got=%b exp=10000",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
         $display("FAIL reset_imem we=%b addr=%0d wdata=%h exp all zero",
                  bus.imem_we, bus.imem_addr, bus.imem_wdata);
         errors++;
      end
      checks++;
      if (bus.rx_ready !== 1'b0) begin
         $display("FAIL reset_rx_ready got=%b exp=0", bus.rx_ready);
         errors++;
      end
      checks++;
      rst = 1'b0;
      #1;
      if (bus.rx_ready !== 1'b1) begin
         $display("FAIL hdr_lo_rx_ready got=%b exp=1", bus.rx_ready);
         errors++;
      end
      checks++;
   endtask

   task automatic test_good_load();
      logic [31:0] exp_data [2];
      exp_data = '{WORD0, WORD1};
      do_reset();
      send_good(11, 0);
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b0_1_0_00) begin
         $display("FAIL good_status got=%b exp=01000",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      if (bus.rx_ready !== 1'b0) begin
         $display("FAIL good_rx_ready got=%b exp=0", bus.rx_ready);
         errors++;
      end
      checks++;
      repeat (3) @(posedge clk);
      #1;
      if (wr_addr_q.size() != 2) begin
         $display("FAIL good_write_count got=%0d exp=2", wr_addr_q.size());
         errors++;
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         if (i >= wr_addr_q.size()) begin
            $display("FAIL good_write%0d got=none exp=addr %0d data %h", i, i, exp_data[i]);
            errors++;
         end else if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_data[i]) begin
            $display("FAIL good_write%0d got=addr %0d data %h exp=addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
            errors++;
         end
         checks++;
      end
   endtask

   task automatic test_bad_checksum();
      logic [31:0] exp_data [2];
      exp_data = '{WORD0, WORD1};
      do_reset();
      send_good(10, 0);
      send_byte(8'h98, 0);
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b1_0_1_10) begin
         $display("FAIL badcsum_status got=%b exp=10110",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      if (wr_addr_q.size() != 2) begin
         $display("FAIL badcsum_write_count got=%0d exp=2", wr_addr_q.size());
         errors++;
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         if (i >= wr_addr_q.size()) begin
            $display("FAIL badcsum_write%0d got=none exp=addr %0d data %h", i, i, exp_data[i]);
            errors++;
         end else if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_data[i]) begin
            $display("FAIL badcsum_write%0d got=addr %0d data %h exp=addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
            errors++;
         end
         checks++;
      end
   endtask

   task automatic test_empty();
      do_reset();
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b0_1_0_00) begin
         $display("FAIL empty_status got=%b exp=01000",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      repeat (2) @(posedge clk);
      #1;
      if (wr_addr_q.size() != 0) begin
         $display("FAIL empty_write_count got=%0d exp=0", wr_addr_q.size());
         errors++;
      end
      checks++;
   endtask

   task automatic test_oversize();
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b1_0_1_01) begin
         $display("FAIL oversize_status got=%b exp=10101",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      if (bus.rx_ready !== 1'b0) begin
         $display("FAIL oversize_rx_ready got=%b exp=0", bus.rx_ready);
         errors++;
      end
      checks++;
      repeat (2) @(posedge clk);
      #1;
      if (wr_addr_q.size() != 0) begin
         $display("FAIL oversize_write_count got=%0d exp=0", wr_addr_q.size());
         errors++;
      end
      checks++;
   endtask

   task automatic test_timeout();
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h93, 0);
      send_byte(8'h00, 0);
      repeat (TMO - 1) @(posedge clk);
      #1;
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b1_0_0_00) begin
         $display("FAIL timeout_early got=%b exp=10000",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      @(posedge clk); #1;
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b1_0_1_11) begin
         $display("FAIL timeout_status got=%b exp=10111",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      if (bus.rx_ready !== 1'b0 || wr_addr_q.size() != 0) begin
         $display("FAIL timeout_quiet got=ready %b writes %0d exp=ready 0 writes 0",
                  bus.rx_ready, wr_addr_q.size());
         errors++;
      end
      checks++;
   endtask

   task automatic test_throttled();
      logic [31:0] exp_data [2];
      exp_data = '{WORD0, WORD1};
      do_reset();
      repeat (3 * TMO) @(posedge clk);
      #1;
      if ({bus.rx_ready, bus.core_rst, bus.done, bus.error, bus.err_code} !== 6'b1_1_0_0_00) begin
         $display("FAIL hdr_lo_wait got=%b exp=110000",
                  {bus.rx_ready, bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      send_good(11, TMO - 1);
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b0_1_0_00) begin
         $display("FAIL throttled_status got=%b exp=01000",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (i >= wr_addr_q.size()) begin
            $display("FAIL throttled_write%0d got=none exp=addr %0d data %h", i, i, exp_data[i]);
            errors++;
         end else if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_data[i]) begin
            $display("FAIL throttled_write%0d got=addr %0d data %h exp=addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
            errors++;
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] exp_data [2];
      exp_data = '{WORD0, WORD1};
      do_reset();
      send_good(6, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b1_0_0_00 ||
          {bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
         $display("FAIL midrst_values got=status %b ready %b we %b addr %0d wdata %h exp=status 10000 rest zero",
                  {bus.core_rst, bus.done, bus.error, bus.err_code},
                  bus.rx_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata);
         errors++;
      end
      checks++;
      rst = 1'b0;
      wr_addr_q.delete();
      wr_data_q.delete();
      send_good(11, 0);
      if ({bus.core_rst, bus.done, bus.error, bus.err_code} !== 5'b0_1_0_00) begin
         $display("FAIL midrst_reload_status got=%b exp=01000",
                  {bus.core_rst, bus.done, bus.error, bus.err_code});
         errors++;
      end
      checks++;
      repeat (2) @(posedge clk);
      #1;
      if (wr_addr_q.size() != 2) begin
         $display("FAIL midrst_write_count got=%0d exp=2", wr_addr_q.size());
         errors++;
      end
      checks++;
      for (int i = 0; i < 2; i++) begin
         if (i >= wr_addr_q.size()) begin
            $display("FAIL midrst_write%0d got=none exp=addr %0d data %h", i, i, exp_data[i]);
            errors++;
         end else if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_data[i]) begin
            $display("FAIL midrst_write%0d got=addr %0d data %h exp=addr %0d data %h",
                     i, wr_addr_q[i], wr_data_q[i], i, exp_data[i]);
            errors++;
         end
         checks++;
      end
   endtask

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      test_reset();
      test_good_load();
      test_bad_checksum();
      test_empty();
      test_oversize();
      test_timeout();
      test_throttled();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Upstream of the five-stage core. Receives a program image as a byte stream and writes it word-by-word into instruction memory. Holds the core in reset until the image has been loaded and its checksum verified. Releases the core (core_rst low) only on a good load; a bad load is reported and the core is kept in reset.

Parameters:
IMEM_DEPTH, 1024, instruction memory depth in 32-bit words; maximum accepted word count
ADDR_W, 10, width of imem_addr; must satisfy 2**ADDR_W >= IMEM_DEPTH
TIMEOUT_CYCLES, 100000, idle cycles allowed between accepted bytes once a load has started

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_valid  in  1  byte available on rx_data
rx_data  in  8  stream byte
rx_ready  out  1  loader can accept a byte; transfer when rx_valid && rx_ready
imem_we  out  1  one-cycle instruction-memory write strobe
imem_addr  out  ADDR_W  word index written
imem_wdata  out  32  assembled instruction word
core_rst  out  1  reset to pipeline core; high until successful load
done  out  1  sticky; load completed and checksum matched
error  out  1  sticky; load failed
err_code  out  2  0 none, 1 size, 2 checksum, 3 timeout

Behaviour:
- Reset values: rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, done=0, error=0, err_code=0, FSM=HDR_LO. Internal word counter, byte counter, checksum and timeout counter are all cleared.
- Frame format:
  - N_lo, N_hi: 16-bit word count N, little-endian.
  - N*4 payload bytes: each word little-endian (first byte = bits 7:0).
  - 1 checksum byte: 8-bit sum, mod 256, of payload bytes only. Header bytes are excluded.
- rx_ready=1 in HDR_LO, HDR_HI, DATA and CHK; 0 in DONE and ERR. It is combinational from state and is never gated by rx_valid.
- FSM transitions (each on an accepted byte unless noted):
  - HDR_LO -> HDR_HI.
  - HDR_HI:
    - N > IMEM_DEPTH -> ERR, err_code=1.
    - N = 0 -> CHK.
    - otherwise -> DATA.
  - DATA:
    - Shift the byte into the word assembler and add it to the checksum.
    - On the 4th byte of a word: the next cycle imem_we=1 for exactly one cycle, with imem_addr = word index (0..N-1) and imem_wdata = assembled word.
    - After the 4th byte of word N-1 -> CHK.
  - CHK:
    - byte == checksum -> DONE.
    - otherwise -> ERR, err_code=2.
  - DONE, ERR: terminal until rst.
- DONE: done=1 and core_rst=0 from the cycle after the checksum byte is accepted.
- ERR: error=1 and core_rst stays 1.
- imem_addr/imem_wdata hold their last values when imem_we=0.
- Timeout:
  - The counter runs in HDR_HI, DATA and CHK.
  - It clears on every accepted byte and on state entry.
  - On reaching TIMEOUT_CYCLES with no accepted byte -> ERR, err_code=3.
  - HDR_LO waits indefinitely.
- Simultaneous events: a byte accepted in the same cycle the timeout count is reached counts as accepted, and no timeout is taken.
- Reset mid-load: everything returns to reset values the next edge. Partially written memory is not cleared; a fresh frame overwrites it.
- Throughput: one byte per cycle sustained; back-to-back rx_valid never stalls.
- No write ever goes to an address >= N. imem_we is never asserted in CHK, DONE or ERR, except for the final word's strobe, which lands in the cycle after entering CHK.

Test Plan:
1. Good two-word load. Stream 02 00 93 00 50 00 13 01 A0 00 97 back-to-back → imem_we pulses at addr 0 with 0x00500093 and at addr 1 with 0x00A00113. The cycle after 0x97 is accepted, done=1, core_rst=0, rx_ready=0.
2. Bad checksum. Same frame with final byte 0x98 → both words written, error=1, err_code=2, core_rst stays 1, done=0.
3. Empty image. Stream 00 00 00 → no imem_we, done=1, core_rst=0.
4. Oversize image. With IMEM_DEPTH=1024, send 01 04 (N=1025) → error=1, err_code=1 right after the 2nd byte, no imem_we, rx_ready=0.
5. Timeout and throttling. Send 01 00 93 00, then hold rx_valid=0 for TIMEOUT_CYCLES (parameter set to 16) → error=1, err_code=3. Separately, gaps of 15 cycles between bytes complete the load normally.
6. Reset mid-load. Pulse rst after the 6th byte of test 1 → outputs return to reset values. A full test-1 stream then succeeds with correct writes and done=1.
